// File: rtl/mvu_stream_ctrl_pkg.sv
// Shared definitions for the MVU stream-slice controller: FSM state type,
// default fold counts and the width helper used to size fold counters/addresses.
// No ports (package).
package mvau_defn;

  // IDLE: between vectors; INPUT: first neuron fold (nf==0, sf>0) consuming
  // fresh beats; REUSE: later folds replaying the input buffer.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_INPUT = 2'd1,
    ST_REUSE = 2'd2
  } state_e;

  localparam int SF_DEF = 4;
  localparam int NF_DEF = 2;

  // $clog2 with a floor of 1 so degenerate folds (count 1) still get a real bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mvu_stream_ctrl_if.sv
// Handshake and buffer/weight-address bundle between the MVU stream controller
// and its slice. master = controller side, slave = datapath/source side.
// Ports: in_v/in_rdy (input beats), out_rdy (downstream), do_mvau, sf_clr,
// ib_wen/ib_ren/ib_addr (input buffer), wmem_addr, vec_done.
interface mvu_stream_ctrl_if #(
  parameter int SF_T        = 2,
  parameter int WMEM_ADDR_W = 3
);
  logic                   in_v;
  logic                   in_rdy;
  logic                   out_rdy;
  logic                   do_mvau;
  logic                   sf_clr;
  logic                   ib_wen;
  logic                   ib_ren;
  logic [SF_T-1:0]        ib_addr;
  logic [WMEM_ADDR_W-1:0] wmem_addr;
  logic                   vec_done;

  modport master (
    input  in_v, out_rdy,
    output in_rdy, do_mvau, sf_clr, ib_wen, ib_ren, ib_addr, wmem_addr, vec_done
  );

  modport slave (
    output in_v, out_rdy,
    input  in_rdy, do_mvau, sf_clr, ib_wen, ib_ren, ib_addr, wmem_addr, vec_done
  );
endinterface

// File: rtl/mvu_stream_ctrl_fold_cnt.sv
// mvu_fold_cnt: modulo-N wrap counter with enable and terminal-count flag.
// Ports: clk, rst_n (sync, active-low), en_i (advance), cnt_o (count),
// tc_o (count == N-1, combinational).
module mvu_fold_cnt #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;

  assign tc_o  = (cnt_q == W'(N - 1));
  assign cnt_o = cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= tc_o ? '0 : cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/mvu_stream_ctrl.sv
// mvu_stream_ctrl: walks SF x NF folds of one MVU slice; writes input beats to the
// buffer on fold 0, replays them on later folds; drives wmem_addr, do_mvau, sf_clr.
// Ports: clk, rst_n (sync, active-low), ctrl (mvu_stream_ctrl_if.master);
// optional perf_busy_cyc/perf_stall_cyc when MVU_STREAM_CTRL_PERF_EN is defined.
module mvu_stream_ctrl
  import mvau_defn::*;
#(
  parameter int SF = SF_DEF,
  parameter int NF = NF_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  mvu_stream_ctrl_if.master   ctrl
`ifdef MVU_STREAM_CTRL_PERF_EN
  ,
  output logic [31:0]         perf_busy_cyc,
  output logic [31:0]         perf_stall_cyc
`endif
);

  localparam int SF_T        = clog2_min1(SF);
  localparam int NF_T        = clog2_min1(NF);
  localparam int WMEM_ADDR_W = clog2_min1(SF * NF);

  state_e          state_q;
  logic [SF_T-1:0] sf_cnt;
  logic [NF_T-1:0] nf_cnt;
  logic            sf_tc;
  logic            nf_tc;
  logic            run;
  logic            in_phase;
  logic            beat;

  // Strobes are gated by rst_n so the reset values hold while reset is applied,
  // even though the outputs are otherwise purely combinational.
  assign run      = rst_n & ctrl.out_rdy;
  // IDLE behaves like INPUT at sf=0, so a new vector starts with no bubble.
  assign in_phase = (state_q != ST_REUSE);
  assign beat     = run & (in_phase ? ctrl.in_v : 1'b1);

  assign ctrl.in_rdy    = run & in_phase;
  assign ctrl.do_mvau   = beat;
  assign ctrl.ib_wen    = beat & in_phase;
  assign ctrl.ib_ren    = beat & ~in_phase;
  assign ctrl.sf_clr    = beat & sf_tc;
  assign ctrl.vec_done  = beat & sf_tc & nf_tc;
  assign ctrl.ib_addr   = sf_cnt;
  assign ctrl.wmem_addr = WMEM_ADDR_W'(nf_cnt) * WMEM_ADDR_W'(SF) + WMEM_ADDR_W'(sf_cnt);

  mvu_fold_cnt #(.N(SF), .W(SF_T)) u_sf_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (beat),
    .cnt_o (sf_cnt),
    .tc_o  (sf_tc)
  );

  mvu_fold_cnt #(.N(NF), .W(NF_T)) u_nf_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (beat & sf_tc),
    .cnt_o (nf_cnt),
    .tc_o  (nf_tc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else if (beat) begin
      if (sf_tc) begin
        state_q <= nf_tc ? ST_IDLE : ST_REUSE;
      end else if (state_q == ST_IDLE) begin
        state_q <= ST_INPUT;
      end
    end
  end

`ifdef MVU_STREAM_CTRL_PERF_EN
  logic [31:0] perf_busy_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      if (beat && (perf_busy_q != '1)) begin
        perf_busy_q <= perf_busy_q + 32'd1;
      end
      if ((state_q != ST_IDLE) && !beat && (perf_stall_q != '1)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_busy_cyc  = perf_busy_q;
  assign perf_stall_cyc = perf_stall_q;
`endif

endmodule

// File: tb/tb_mvu_stream_ctrl.sv
// Bench for mvu_stream_ctrl: directed vector table (SF=4,NF=2), hand sequences for
// reset/stall corners and SF=1,NF=1, plus random stimulus vs a linear-index model.
// Ports: none (top-level bench).
module tb_mvu_stream_ctrl;
  import mvau_defn::*;

  typedef struct {
    logic in_v, out_rdy;
    logic rdy, dom, clr, wen, ren, done;
    int   addr, wmem;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   ka = 0;
  int   kb = 0;
  int   busy_m = 0;
  int   stall_m = 0;

  always #5 clk = ~clk;

  mvu_stream_ctrl_if #(.SF_T(2), .WMEM_ADDR_W(3)) if_a ();
  mvu_stream_ctrl_if #(.SF_T(1), .WMEM_ADDR_W(1)) if_b ();

`ifdef MVU_STREAM_CTRL_PERF_EN
  logic [31:0] busy_a, stall_a, busy_b, stall_b;
`endif

  mvu_stream_ctrl #(.SF(4), .NF(2)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .ctrl  (if_a)
`ifdef MVU_STREAM_CTRL_PERF_EN
    , .perf_busy_cyc (busy_a), .perf_stall_cyc (stall_a)
`endif
  );

  mvu_stream_ctrl #(.SF(1), .NF(1)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .ctrl  (if_b)
`ifdef MVU_STREAM_CTRL_PERF_EN
    , .perf_busy_cyc (busy_b), .perf_stall_cyc (stall_b)
`endif
  );

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cmp(string nm, vec_t a, vec_t e);
    chk({nm, " in_rdy"},    int'(a.rdy),  int'(e.rdy));
    chk({nm, " do_mvau"},   int'(a.dom),  int'(e.dom));
    chk({nm, " sf_clr"},    int'(a.clr),  int'(e.clr));
    chk({nm, " ib_wen"},    int'(a.wen),  int'(e.wen));
    chk({nm, " ib_ren"},    int'(a.ren),  int'(e.ren));
    chk({nm, " vec_done"},  int'(a.done), int'(e.done));
    chk({nm, " ib_addr"},   a.addr, e.addr);
    chk({nm, " wmem_addr"}, a.wmem, e.wmem);
  endtask

  function automatic vec_t mk(logic v, logic r, logic rdy, logic dom, logic clr,
                              logic wen, logic ren, int addr, int wmem, logic done);
    vec_t t;
    t.in_v = v; t.out_rdy = r; t.rdy = rdy; t.dom = dom; t.clr = clr;
    t.wen = wen; t.ren = ren; t.addr = addr; t.wmem = wmem; t.done = done;
    return t;
  endfunction

  function automatic vec_t act_a();
    return mk(if_a.in_v, if_a.out_rdy, if_a.in_rdy, if_a.do_mvau, if_a.sf_clr,
              if_a.ib_wen, if_a.ib_ren, int'(if_a.ib_addr), int'(if_a.wmem_addr), if_a.vec_done);
  endfunction

  function automatic vec_t act_b();
    return mk(if_b.in_v, if_b.out_rdy, if_b.in_rdy, if_b.do_mvau, if_b.sf_clr,
              if_b.ib_wen, if_b.ib_ren, int'(if_b.ib_addr), int'(if_b.wmem_addr), if_b.vec_done);
  endfunction

  // Reference: k is the beat index within the vector (0..SF*NF-1); sf/nf, the
  // weight address and all strobes follow from k by plain arithmetic.
  function automatic vec_t model(int sfn, int nfn, int k, logic v, logic r, logic rs);
    int   s = k % sfn;
    int   n = k / sfn;
    logic inph = (n == 0);
    logic b = rs && r && (!inph || v);
    return mk(v, r, rs && r && inph, b, b && (s == sfn - 1), b && inph, b && !inph,
              s, k, b && (k == sfn * nfn - 1));
  endfunction

  task automatic step_a(string nm, logic v, logic r, logic rs);
    vec_t e;
    @(negedge clk);
    if_a.in_v = v; if_a.out_rdy = r; rst_n = rs;
    #1;
    e = model(4, 2, ka, v, r, rs);
    cmp(nm, act_a(), e);
`ifdef MVU_STREAM_CTRL_PERF_EN
    chk({nm, " perf_busy"},  int'(busy_a),  busy_m);
    chk({nm, " perf_stall"}, int'(stall_a), stall_m);
`endif
    if (!rs) begin
      ka = 0; busy_m = 0; stall_m = 0;
    end else begin
      if (!e.dom && ka != 0) stall_m++;
      if (e.dom) begin
        busy_m++;
        ka = (ka + 1) % 8;
      end
    end
  endtask

  task automatic step_b(string nm, logic v, logic r, logic rs);
    @(negedge clk);
    if_b.in_v = v; if_b.out_rdy = r; rst_n = rs;
    #1;
    cmp(nm, act_b(), model(1, 1, kb, v, r, rs));
    chk({nm, " state"}, int'(dut_b.state_q), int'(ST_IDLE));
`ifdef MVU_STREAM_CTRL_PERF_EN
    chk({nm, " perf_stall"}, int'(stall_b), 0);
`endif
  endtask

  vec_t tv[22];

  initial begin
    // Scenario: 8 straight beats; then in_v gap after beat 2; then out_rdy stall in REUSE at sf=2.
    tv[0]  = mk(1,1, 1,1,0,1,0, 0,0,0);
    tv[1]  = mk(1,1, 1,1,0,1,0, 1,1,0);
    tv[2]  = mk(1,1, 1,1,0,1,0, 2,2,0);
    tv[3]  = mk(1,1, 1,1,1,1,0, 3,3,0);
    tv[4]  = mk(1,1, 0,1,0,0,1, 0,4,0);
    tv[5]  = mk(1,1, 0,1,0,0,1, 1,5,0);
    tv[6]  = mk(1,1, 0,1,0,0,1, 2,6,0);
    tv[7]  = mk(1,1, 0,1,1,0,1, 3,7,1);
    tv[8]  = mk(1,1, 1,1,0,1,0, 0,0,0);
    tv[9]  = mk(1,1, 1,1,0,1,0, 1,1,0);
    tv[10] = mk(0,1, 1,0,0,0,0, 2,2,0);
    tv[11] = mk(0,1, 1,0,0,0,0, 2,2,0);
    tv[12] = mk(1,1, 1,1,0,1,0, 2,2,0);
    tv[13] = mk(1,1, 1,1,1,1,0, 3,3,0);
    tv[14] = mk(1,1, 0,1,0,0,1, 0,4,0);
    tv[15] = mk(1,1, 0,1,0,0,1, 1,5,0);
    tv[16] = mk(1,0, 0,0,0,0,0, 2,6,0);
    tv[17] = mk(1,0, 0,0,0,0,0, 2,6,0);
    tv[18] = mk(1,0, 0,0,0,0,0, 2,6,0);
    tv[19] = mk(1,1, 0,1,0,0,1, 2,6,0);
    tv[20] = mk(1,1, 0,1,1,0,1, 3,7,1);
    tv[21] = mk(0,1, 1,0,0,0,0, 0,0,0);

    rst_n = 1'b0;
    if_a.in_v = 1'b1; if_a.out_rdy = 1'b1;
    if_b.in_v = 1'b0; if_b.out_rdy = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    cmp("reset", act_a(), mk(1,1, 0,0,0,0,0, 0,0,0));
    chk("reset state", int'(dut_a.state_q), int'(ST_IDLE));

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      if_a.in_v = tv[i].in_v; if_a.out_rdy = tv[i].out_rdy; rst_n = 1'b1;
      #1;
      cmp($sformatf("vec%0d", i), act_a(), tv[i]);
    end
`ifdef MVU_STREAM_CTRL_PERF_EN
    chk("table perf_busy",  int'(busy_a),  16);
    chk("table perf_stall", int'(stall_a), 5);
`endif
    ka = 0; busy_m = 16; stall_m = 5;

    // Reset while in INPUT at sf=3.
    for (int i = 0; i < 3; i++) step_a("pre_rst", 1'b1, 1'b1, 1'b1);
    step_a("rst_mid", 1'b1, 1'b1, 1'b0);
    step_a("rst_hold", 1'b1, 1'b1, 1'b0);
    chk("rst_hold state", int'(dut_a.state_q), int'(ST_IDLE));
    step_a("after_rst", 1'b1, 1'b1, 1'b1);
    chk("after_rst wmem", int'(if_a.wmem_addr), 0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      step_a("rand_a", $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
             $urandom_range(0, 99) != 0);
    end

    // Full vector with a 2-cycle downstream stall in REUSE.
    step_a("perf_rst", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step_a("perf_beat", 1'b1, 1'b1, 1'b1);
    step_a("perf_stall", 1'b1, 1'b0, 1'b1);
    step_a("perf_stall", 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step_a("perf_beat", 1'b1, 1'b1, 1'b1);
    step_a("perf_idle", 1'b0, 1'b1, 1'b1);
`ifdef MVU_STREAM_CTRL_PERF_EN
    chk("perf_busy final",  int'(busy_a),  8);
    chk("perf_stall final", int'(stall_a), 2);
`endif
    if_a.in_v = 1'b0; if_a.out_rdy = 1'b0;

    // SF=1, NF=1: every accepted beat closes row and vector.
    step_b("b_beat", 1'b1, 1'b1, 1'b1);
    chk("b_beat sf_clr", int'(if_b.sf_clr), 1);
    chk("b_beat vec_done", int'(if_b.vec_done), 1);
    step_b("b_beat2", 1'b1, 1'b1, 1'b1);
    step_b("b_nov", 1'b0, 1'b1, 1'b1);
    step_b("b_stall", 1'b1, 1'b0, 1'b1);
    chk("b_stall sf_clr", int'(if_b.sf_clr), 0);
    for (int i = 0; i < 60; i++) begin
      step_b("rand_b", $urandom_range(0, 1) != 0, $urandom_range(0, 3) != 0,
             $urandom_range(0, 29) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mvu_stream_ctrl.md
Name: mvu_stream_ctrl

Overview:
- Control sequencer for one MVU stream slice. It walks the synapse-fold (SF) and neuron-fold (NF) loops of a matrix-vector product.
- It accepts input-activation beats over a valid/ready handshake and stores them in the input buffer on the first neuron fold, then replays them from the buffer on every later fold.
- It drives the weight-memory address and the per-beat datapath enable.
- It generates sf_clr, which marks the last accumulation beat, for every PE accumulator in the slice.

Parameters:
- SF, 4, synapse folds per output row (MatrixW/SIMD), >=1
- NF, 2, neuron folds per input vector (MatrixH/PE), >=1
- SF_T, $clog2(SF) (min 1), SF counter / buffer address width
- NF_T, $clog2(NF) (min 1), NF counter width
- WMEM_ADDR_W, $clog2(SF*NF) (min 1), weight memory address width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- in_v  in  1  input activation beat valid
- in_rdy  out  1  controller accepts input beat this cycle
- out_rdy  in  1  downstream can absorb results; low freezes sequencing
- do_mvau  out  1  datapath computes on this beat
- sf_clr  out  1  last SF beat of current row, to accumulators
- ib_wen  out  1  input buffer write enable
- ib_ren  out  1  input buffer read enable
- ib_addr  out  SF_T  input buffer address (= sf count)
- wmem_addr  out  WMEM_ADDR_W  weight memory address, nf*SF+sf
- vec_done  out  1  one-cycle pulse on final beat of final fold

Behaviour:
- Reset: state IDLE. sf=0, nf=0. in_rdy, do_mvau, sf_clr, ib_wen, ib_ren, vec_done = 0. ib_addr=0, wmem_addr=0.
- All outputs are combinational from state, counters and in_v/out_rdy. There is no added latency: beat acceptance, do_mvau and the addresses coincide in the same cycle.
- Define beat = (state==INPUT && in_v && out_rdy) || (state==REUSE && out_rdy).
- IDLE:
  - in_rdy = out_rdy.
  - A beat (in_v && out_rdy) is processed as INPUT sf=0 in the same cycle; go to INPUT (or REUSE/IDLE per the counter rules below).
- INPUT (nf==0):
  - in_rdy = out_rdy.
  - On beat: do_mvau=1, ib_wen=1, ib_addr=sf.
  - in_v low: no beat; counters hold.
- REUSE (nf>0):
  - in_rdy = 0, ib_ren = out_rdy, do_mvau = out_rdy.
- Counter advance on beat:
  - sf==SF-1: sf_clr=1, sf<=0. Then:
    - nf==NF-1: nf<=0, vec_done=1, go to IDLE.
    - otherwise: nf<=nf+1, go to REUSE.
  - otherwise: sf<=sf+1.
- Downstream stall: out_rdy=0 blocks every beat. Counters, state and addresses hold; all strobes are 0. This guarantees accumulator results (valid 4 cycles after sf_clr) are never overwritten while downstream is stalled.
- SF=1: sf_clr on every beat.
- NF=1: REUSE is never entered; ib_ren is never asserted. The buffer is written but unused.
- SF=1 and NF=1: every accepted beat pulses sf_clr and vec_done.
- Back-to-back vectors:
  - Transition is IDLE -> INPUT on the same cycle the next beat arrives, with no bubble.
  - Throughput is one beat per cycle with in_v and out_rdy held high.
- Reset mid-operation: abandon the vector and return to the reset state. Partial accumulator contents are discarded by the accumulators' own reset.
- wmem_addr counts nf*SF+sf. Wrap from SF*NF-1 to 0 coincides with vec_done.

Optional Feature:
- Macro: MVU_STREAM_CTRL_PERF_EN.
- When defined, add output ports perf_busy_cyc [31:0] and perf_stall_cyc [31:0]:
  - perf_busy_cyc counts beats.
  - perf_stall_cyc counts cycles with state!=IDLE and no beat.
  - Both saturate at 2^32-1 and reset to 0.
- When undefined, the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package mvau_defn: state enum typedef (IDLE, INPUT, REUSE) and SF/NF-derived width constants.
- Natural sub-module: mvu_fold_cnt, a parameterised wrap counter with enable, terminal-count output and sync reset. Instantiate it twice, for sf and nf.

Test Plan:
- SF=4, NF=2, in_v and out_rdy high, 4 beats:
  - 8 do_mvau cycles.
  - sf_clr on cycles 4 and 8.
  - ib_wen on cycles 1-4, ib_ren on cycles 5-8.
  - wmem_addr 0..7.
  - vec_done on cycle 8.
  - in_rdy low on cycles 5-8.
- Same config, in_v low for 2 cycles after beat 2: counters hold, no strobes; sf_clr still after the 4th accepted beat; ib_addr sequence 0,1,2,3 unbroken.
- out_rdy low for 3 cycles mid-REUSE at sf=2: do_mvau, ib_ren, sf_clr all 0 for 3 cycles; resume at sf=2, wmem_addr=6.
- SF=1, NF=1: each accepted beat pulses sf_clr and vec_done; state stays IDLE.
- rst_n low at INPUT sf=3: the next cycle shows state IDLE and all outputs at reset values. The next vector starts at wmem_addr=0.
- With MVU_STREAM_CTRL_PERF_EN, first scenario plus a 2-cycle out_rdy stall: perf_busy_cyc=8, perf_stall_cyc=2.
